// File: rtl/audio_i2s_tx_if.sv
// audio_if: codec link carrying master clock, I2S data and word select.
// The transmitter drives mclk/dac/lrck; adc belongs to the codec side.
interface audio_if;
  logic mclk;
  logic dac;
  logic lrck;
  logic adc;

  modport tx (
    output mclk,
    output dac,
    output lrck
  );

  modport codec (
    input  mclk,
    input  dac,
    input  lrck,
    output adc
  );
endinterface

// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter: FIFO of {L,R} frames serialised at 256 mclk/frame.
// AUDIO_I2S_TX_HOLD_ON_UNDERRUN_EN: repeat last frame on underrun instead of silence.
module audio_i2s_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_12_288_mhz,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_left,
  input  logic [SAMPLE_W-1:0] sample_right,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                frame_strobe,
  output logic [15:0]         underrun_count,
  audio_if.tx                 audio
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]          phase;
  logic [7:0]          phase_nxt;
  logic [SAMPLE_W-1:0] mem_l [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [SAMPLE_W-1:0] frame_l;
  logic [SAMPLE_W-1:0] frame_r;
  logic                dac_q;
  logic                dac_nxt;
  logic                empty;
  logic                full;
  logic                push;
  logic                load;
  logic                pop;
  logic [4:0]          bit_k;
  logic [SAMPLE_W-1:0] sel;
  logic [SAMPLE_W-1:0] slot;

  assign phase_nxt = phase + 8'd1;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign sample_ready = !full && !reset;
  assign push = sample_valid && sample_ready;
  assign load = (phase == 8'hFF);
  assign pop  = load && !empty;

  assign frame_strobe = load;
  assign audio.mclk   = clk_12_288_mhz;
  assign audio.lrck   = phase[7];
  assign audio.dac    = dac_q;

  // Slot bit for the phase about to start; k=0 is the I2S 1-bit delay.
  assign bit_k = phase_nxt[6:2];
  assign sel   = phase_nxt[7] ? frame_r : frame_l;

  always_comb begin
    dac_nxt = 1'b0;
    slot    = '0;
    if (bit_k != 5'd0 && {1'b0, bit_k} <= 6'(SAMPLE_W)) begin
      slot    = sel >> (6'(SAMPLE_W) - {1'b0, bit_k});
      dac_nxt = slot[0];
    end
  end

  always_ff @(posedge clk_12_288_mhz) begin
    if (push) begin
      mem_l[wr_ptr[AW-1:0]] <= sample_left;
      mem_r[wr_ptr[AW-1:0]] <= sample_right;
    end
  end

  always_ff @(posedge clk_12_288_mhz) begin
    if (reset) begin
      phase          <= 8'h00;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      frame_l        <= '0;
      frame_r        <= '0;
      dac_q          <= 1'b0;
      underrun_count <= 16'h0000;
    end else begin
      phase <= phase_nxt;
      dac_q <= dac_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        frame_l <= mem_l[rd_ptr[AW-1:0]];
        frame_r <= mem_r[rd_ptr[AW-1:0]];
      end else if (load) begin
        if (underrun_count != 16'hFFFF) begin
          underrun_count <= underrun_count + 16'd1;
        end
`ifdef AUDIO_I2S_TX_HOLD_ON_UNDERRUN_EN
        frame_l <= frame_l;
        frame_r <= frame_r;
`else
        frame_l <= '0;
        frame_r <= '0;
`endif
      end
    end
  end

endmodule
